// File: rtl/fir_sched_pkg.sv
// Shared types, widths and result rounding for the FIR channel scheduler.
// FIR_SCHED_SAT_EN selects clamping instead of wrap-around narrowing.
package fir_sched_pkg;
  localparam int NCH_DEF     = 4;
  localparam int TAPS_DEF    = 128;
  localparam int DW_DEF      = 18;
  localparam int ACCW_DEF    = 48;
  localparam int SHIFT_DEF   = 8;
  localparam int MAC_LAT_DEF = 2;
  localparam int CH_W        = $clog2(NCH_DEF);
  localparam int TAP_W       = $clog2(TAPS_DEF);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN, S_WAIT, S_OUT} state_t;

  localparam logic [ACCW_DEF:0] RND =
    {{(ACCW_DEF-SHIFT_DEF+1){1'b0}}, 1'b1, {(SHIFT_DEF-1){1'b0}}};
`ifdef FIR_SCHED_SAT_EN
  localparam logic [ACCW_DEF:0] SAT_HI = {{(ACCW_DEF-DW_DEF+2){1'b0}}, {(DW_DEF-1){1'b1}}};
  localparam logic [ACCW_DEF:0] SAT_LO = {{(ACCW_DEF-DW_DEF+2){1'b1}}, {(DW_DEF-1){1'b0}}};
`endif

  // One guard bit above the accumulator keeps the rounding add from overflowing.
  function automatic logic [DW_DEF-1:0] round_sat(input logic [ACCW_DEF-1:0] acc);
    logic signed [ACCW_DEF:0] s;
    s = $signed({acc[ACCW_DEF-1], acc}) + $signed(RND);
    s = s >>> SHIFT_DEF;
`ifdef FIR_SCHED_SAT_EN
    if (s > $signed(SAT_HI))      return SAT_HI[DW_DEF-1:0];
    else if (s < $signed(SAT_LO)) return SAT_LO[DW_DEF-1:0];
    else                          return s[DW_DEF-1:0];
`else
    return s[DW_DEF-1:0];
`endif
  endfunction
endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin grant over N requests; priority pointer moves past adv_idx on adv.
module fir_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  input  logic [W-1:0] adv_idx,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  logic [W-1:0] ptr_q, ptr_d;

  // Scan from farthest to nearest offset so the nearest request wins.
  always_comb begin
    logic [W-1:0] idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      idx = ptr_q + W'(i);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
    gnt   = gnt_vld ? (N'(1) << gnt_idx) : '0;
    ptr_d = adv ? adv_idx + W'(1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one serial-MAC FIR datapath across NCH channels: clears the delay lines,
// arbitrates samples, sequences taps and returns rounded results (FIR_SCHED_SAT_EN clamps).
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int TAPS    = TAPS_DEF,
  parameter int DW      = DW_DEF,
  parameter int ACCW    = ACCW_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*DW-1:0]        in_data,
  output logic [NCH-1:0]           in_ready,
  output logic                     wr_en,
  output logic [$clog2(NCH)-1:0]   wr_ch,
  output logic [$clog2(TAPS)-1:0]  wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic                     mac_clr,
  output logic                     mac_en,
  output logic                     mac_last,
  output logic [$clog2(NCH)-1:0]   mac_ch,
  output logic [$clog2(TAPS)-1:0]  mac_tap,
  output logic [$clog2(TAPS)-1:0]  mac_addr,
  input  logic [ACCW-1:0]          acc_in,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready
);
  localparam int CW  = $clog2(NCH);
  localparam int TW  = $clog2(TAPS);
  localparam int CLW = CW + TW;

  state_t                   state_q, state_d;
  logic [CLW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]            k_q, k_d;
  logic [CW-1:0]            g_q, g_d;
  logic [TW-1:0]            base_q, base_d;
  logic [DW-1:0]            smp_q, smp_d;
  logic [DW-1:0]            res_q, res_d;
  logic [NCH-1:0][TW-1:0]   wptr_q, wptr_d;

  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_vld;
  logic           adv;

  assign adv = !rst && (state_q == S_OUT) && out_ready;

  fir_rr_arbiter #(.N(NCH), .W(CW)) u_arb (
    .clk(clk), .rst(rst), .req(in_valid), .adv(adv), .adv_idx(g_q),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
  );

  assign out_ch   = g_q;
  assign out_data = res_q;

  // Outputs are gated by rst so every strobe reads 0 while reset is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    g_d       = g_q;
    base_d    = base_q;
    smp_d     = smp_q;
    res_d     = res_q;
    wptr_d    = wptr_q;
    in_ready  = '0;
    wr_en     = 1'b0;
    wr_ch     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_last  = 1'b0;
    mac_ch    = '0;
    mac_tap   = '0;
    mac_addr  = '0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        S_CLEAR: begin
          wr_en   = 1'b1;
          wr_ch   = cnt_q[CLW-1:TW];
          wr_addr = cnt_q[TW-1:0];
          cnt_d   = cnt_q + CLW'(1);
          if (&cnt_q) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (gnt_vld) begin
            in_ready = gnt;
            g_d      = gnt_idx;
            smp_d    = in_data[gnt_idx*DW +: DW];
            base_d   = wptr_q[gnt_idx];
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          wr_en          = 1'b1;
          wr_ch          = g_q;
          wr_addr        = base_q;
          wr_data        = smp_q;
          mac_clr        = 1'b1;
          wptr_d[g_q]    = wptr_q[g_q] + TW'(1);
          k_d            = '0;
          state_d        = S_RUN;
        end
        S_RUN: begin
          mac_en   = 1'b1;
          mac_ch   = g_q;
          mac_tap  = k_q;
          mac_addr = base_q - k_q;
          k_d      = k_q + TW'(1);
          if (&k_q) begin
            mac_last = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CLW'(1);
          if (cnt_q == CLW'(MAC_LAT-1)) begin
            res_d   = round_sat(acc_in);
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          out_valid = 1'b1;
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      k_q     <= '0;
      g_q     <= '0;
      base_q  <= '0;
      smp_q   <= '0;
      res_q   <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      g_q     <= g_d;
      base_q  <= base_d;
      smp_q   <= smp_d;
      res_q   <= res_d;
      wptr_q  <= wptr_d;
    end
  end
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler with a behavioural sample-RAM/MAC model.
module tb_fir_channel_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [71:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [6:0]  wr_addr;
  logic [17:0] wr_data;
  logic        mac_clr, mac_en, mac_last;
  logic [1:0]  mac_ch;
  logic [6:0]  mac_tap, mac_addr;
  logic [47:0] acc_in;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [17:0] out_data;
  logic        out_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  fir_channel_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last), .mac_ch(mac_ch),
    .mac_tap(mac_tap), .mac_addr(mac_addr), .acc_in(acc_in),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Datapath model: coef[0]=1.0, coef[1]=0.5 (scaled by 256), acc_in two cycles after last mac_en.
  logic signed [17:0] mem [4][128];
  longint acc_r = 0, acc_d1 = 0;
  logic        use_model = 1'b1;
  logic [47:0] acc_force = '0;
  assign acc_in = use_model ? acc_d1[47:0] : acc_force;

  always @(posedge clk) begin
    if (wr_en) mem[wr_ch][wr_addr] <= $signed(wr_data);
    if (mac_clr) acc_r <= 0;
    else if (mac_en)
      acc_r <= acc_r + ((mac_tap == 7'd0) ? 256 : (mac_tap == 7'd1) ? 128 : 0) *
                       longint'(mem[mac_ch][mac_addr]);
    acc_d1 <= acc_r;
  end

  task automatic apply_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (513) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({wr_en, in_ready, mac_clr, mac_en, mac_last, out_valid} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {wr_en, in_ready, mac_clr, mac_en, mac_last, out_valid});
    end
    n_chk++;
    if ({out_data, out_ch} !== 20'd0) begin
      n_fail++; $display("FAIL reset_out: got data=%h ch=%0d want 0", out_data, out_ch);
    end
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 4'hf;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      n_chk++;
      if ({wr_en, wr_ch, wr_addr, wr_data, in_ready} !== {1'b1, 2'(i >> 7), 7'(i), 18'd0, 4'd0}) begin
        n_fail++;
        $display("FAIL clear_sweep[%0d]: got en=%b ch=%0d addr=%0d data=%h rdy=%b want 1,%0d,%0d,0,0",
                 i, wr_en, wr_ch, wr_addr, wr_data, in_ready, i >> 7, i & 127);
      end
      if (i == 511) in_valid = '0;
    end
    @(negedge clk);
    n_chk++;
    if ({wr_en, in_ready} !== 5'd0) begin
      n_fail++; $display("FAIL clear_end: got wr_en=%b in_ready=%b want 0", wr_en, in_ready);
    end
  endtask

  task automatic test_single();
    use_model = 1'b1;
    in_data = '0;
    in_data[2*18 +: 18] = 18'd1000;
    in_valid = 4'b0100;
    #1;
    n_chk++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b want 0100", in_ready);
    end
    @(negedge clk);
    in_valid = '0;
    #1;
    n_chk++;
    if ({wr_en, wr_ch, wr_addr, wr_data, mac_clr, mac_en, in_ready} !== {1'b1, 2'd2, 7'd0, 18'd1000, 1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL single_load: got en=%b ch=%0d addr=%0d data=%0d clr=%b", wr_en, wr_ch, wr_addr, wr_data, mac_clr);
    end
    for (int k = 0; k < 128; k++) begin
      @(negedge clk); #1;
      n_chk++;
      if ({mac_en, mac_ch, mac_tap, mac_addr, mac_last, wr_en} !== {1'b1, 2'd2, 7'(k), 7'(-k), (k == 127), 1'b0}) begin
        n_fail++;
        $display("FAIL single_tap[%0d]: got en=%b ch=%0d tap=%0d addr=%0d last=%b want addr %0d",
                 k, mac_en, mac_ch, mac_tap, mac_addr, mac_last, (128 - k) & 127);
      end
    end
    for (int w = 0; w < 2; w++) begin
      @(negedge clk); #1;
      n_chk++;
      if ({mac_en, mac_last, out_valid} !== 3'd0) begin
        n_fail++; $display("FAIL single_wait[%0d]: got en=%b last=%b ov=%b want 0", w, mac_en, mac_last, out_valid);
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 18'd1000}) begin
      n_fail++; $display("FAIL single_out: got ov=%b ch=%0d data=%0d want 1,2,1000", out_valid, out_ch, $signed(out_data));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_ov_clear: got %b want 0", out_valid);
    end
  endtask

  task automatic test_rr();
    int exp_ch [5]  = '{0, 1, 2, 3, 0};
    int exp_out [5] = '{200, -300, 500, 7, 700};
    int t;
    apply_reset();
    use_model = 1'b1;
    in_data[0*18 +: 18] = 18'(200);
    in_data[1*18 +: 18] = 18'(-300);
    in_data[2*18 +: 18] = 18'(500);
    in_data[3*18 +: 18] = 18'(7);
    in_valid = 4'hf;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      t = 0; #1;
      while (in_ready == 4'd0 && t < 300) begin @(negedge clk); #1; t++; end
      n_chk++;
      if (in_ready !== 4'(1 << exp_ch[n])) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want ch%0d", n, in_ready, exp_ch[n]);
      end
      @(negedge clk);
      if (n == 0) in_data[0*18 +: 18] = 18'(600);
      if (n == 4) in_valid = '0;
      #1;
      if (n == 4) begin
        n_chk++;
        if ({wr_en, wr_ch, wr_addr} !== {1'b1, 2'd0, 7'd1}) begin
          n_fail++; $display("FAIL rr_wptr: got en=%b ch=%0d addr=%0d want 1,0,1", wr_en, wr_ch, wr_addr);
        end
        @(negedge clk); #1;
        n_chk++;
        if ({mac_en, mac_addr} !== {1'b1, 7'd1}) begin
          n_fail++; $display("FAIL rr_first_addr: got en=%b addr=%0d want 1,1", mac_en, mac_addr);
        end
      end
      t = 0;
      while (!out_valid && t < 300) begin @(negedge clk); #1; t++; end
      n_chk++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'(exp_ch[n]), 18'(exp_out[n])}) begin
        n_fail++; $display("FAIL rr_out[%0d]: got ov=%b ch=%0d data=%0d want ch%0d %0d",
                           n, out_valid, out_ch, $signed(out_data), exp_ch[n], exp_out[n]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_rounding();
    longint vals [6] = '{384, -128, -129, 127, 64'sd1 <<< 40, -(64'sd1 <<< 40)};
`ifdef FIR_SCHED_SAT_EN
    int exp [6] = '{2, 0, -1, 0, 131071, -131072};
`else
    int exp [6] = '{2, 0, -1, 0, 0, 0};
`endif
    int t, ch;
    use_model = 1'b0;
    for (int n = 0; n < 6; n++) begin
      ch = n % 4;
      acc_force = 48'(vals[n]);
      in_data[ch*18 +: 18] = 18'd1;
      in_valid = 4'(1 << ch);
      t = 0; #1;
      while (in_ready == 4'd0 && t < 300) begin @(negedge clk); #1; t++; end
      @(negedge clk);
      in_valid = '0;
      t = 0; #1;
      while (!out_valid && t < 300) begin @(negedge clk); #1; t++; end
      n_chk++;
      if ({out_valid, out_data} !== {1'b1, 18'(exp[n])}) begin
        n_fail++; $display("FAIL round[%0d]: acc=%0d got ov=%b data=%0d want %0d",
                           n, vals[n], out_valid, $signed(out_data), exp[n]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    int t;
    use_model = 1'b0;
    acc_force = 48'd14080;
    in_valid = 4'b0010;
    t = 0; #1;
    while (in_ready == 4'd0 && t < 300) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    in_valid = 4'hf;
    t = 0; #1;
    while (!out_valid && t < 300) begin @(negedge clk); #1; t++; end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd1, 18'd55, 4'd0}) begin
        n_fail++; $display("FAIL stall[%0d]: got ov=%b ch=%0d data=%0d rdy=%b want 1,1,55,0",
                           i, out_valid, out_ch, $signed(out_data), in_ready);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = '0;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int t;
    int bad;
    use_model = 1'b1;
    in_data[3*18 +: 18] = 18'd50;
    in_valid = 4'b1000;
    t = 0; #1;
    while (in_ready == 4'd0 && t < 300) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    in_valid = '0;
    t = 0; #1;
    while (!(mac_en && mac_tap == 7'd60) && t < 300) begin @(negedge clk); #1; t++; end
    n_chk++;
    if ({mac_en, mac_tap} !== {1'b1, 7'd60}) begin
      n_fail++; $display("FAIL midrst_reach: got en=%b tap=%0d want 1,60", mac_en, mac_tap);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({out_valid, mac_en, wr_en, in_ready} !== 7'd0) begin
      n_fail++; $display("FAIL midrst_hold: got ov=%b en=%b wr=%b rdy=%b want 0", out_valid, mac_en, wr_en, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
      if (i == 0) begin
        n_chk++;
        if ({wr_en, wr_ch, wr_addr} !== {1'b1, 2'd0, 7'd0}) begin
          n_fail++; $display("FAIL midrst_clear: got en=%b ch=%0d addr=%0d want 1,0,0", wr_en, wr_ch, wr_addr);
        end
      end
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL midrst_no_out: got %0d out_valid cycles want 0", bad);
    end
    in_data[3*18 +: 18] = 18'd77;
    in_valid = 4'b1000;
    t = 0; #1;
    while (in_ready == 4'd0 && t < 300) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    in_valid = '0;
    #1;
    n_chk++;
    if ({wr_en, wr_ch, wr_addr, wr_data} !== {1'b1, 2'd3, 7'd0, 18'd77}) begin
      n_fail++; $display("FAIL midrst_wptr: got en=%b ch=%0d addr=%0d data=%0d want 1,3,0,77", wr_en, wr_ch, wr_addr, wr_data);
    end
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); #1; t++; end
    n_chk++;
    if ({out_valid, out_data} !== {1'b1, 18'd77}) begin
      n_fail++; $display("FAIL midrst_out: got ov=%b data=%0d want 77", out_valid, $signed(out_data));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_rounding();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
